// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: update-side controller for the branch history table.
//   Holds fetch-time predictions in an in-order FIFO and resolves the oldest one
//   when EX reports the real outcome. Each resolution produces a registered BHT
//   update pulse. A misprediction also produces a redirect pulse and flushes all
//   younger (wrong-path) entries.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   enq_valid/pc/pred_taken/pred_target  prediction from fetch
//   enq_ready                          !full
//   res_valid/res_taken/res_target     outcome of the oldest branch from EX
//   PC_lower_update, update, update_direction   BHT update port (registered)
//   mispredict, redirect_pc            redirect to fetch (registered)
//   count, empty                       occupancy
//   res_err                            sticky: resolve arrived while empty
module bpu_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5,
  parameter int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_valid,
  input  logic [PC_W-1:0]  enq_pc,
  input  logic             enq_pred_taken,
  input  logic [PC_W-1:0]  enq_pred_target,
  output logic             enq_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic [IDX_W-1:0] PC_lower_update,
  output logic             update,
  output logic             update_direction,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             res_err
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  entry_t             head;
  logic               full, enq_fire, res_fire, mis, flush;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full;
  assign enq_fire  = enq_valid && !full;
  assign res_fire  = res_valid && !empty;
  assign head      = mem[rd_ptr];

  // Direction wrong, or both taken but to a different target.
  assign mis   = (head.pred_taken != res_taken) ||
                 (head.pred_taken && res_taken && (head.pred_target != res_target));
  assign flush = res_fire && mis;

  // Storage has no reset; occupancy is tracked by count/pointers. A same-cycle
  // enqueue during a flush is wrong-path and never written.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush)
      mem[wr_ptr] <= '{pc: enq_pc, pred_taken: enq_pred_taken, pred_target: enq_pred_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      update           <= 1'b0;
      mispredict       <= 1'b0;
      res_err          <= 1'b0;
      PC_lower_update  <= '0;
      update_direction <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      update     <= res_fire;
      mispredict <= flush;
      if (res_fire) begin
        PC_lower_update  <= head.pc[IDX_W-1:0];
        update_direction <= res_taken;
        redirect_pc      <= res_taken ? res_target : head.pc + PC_W'(4);
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (res_valid && empty)
        res_err <= 1'b1;

      if (flush) begin
        // Everything younger than the popped head is wrong-path.
        wr_ptr <= rd_ptr + PTR_W'(1);
        count  <= '0;
      end else begin
        if (enq_fire)
          wr_ptr <= wr_ptr + PTR_W'(1);
        unique case ({enq_fire, res_fire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Scoreboard bench for bpu_update_ctrl: the stimulus side keeps a queue model of
// the in-flight branches and pushes expected update/redirect results; a monitor
// on the falling edge pops and compares whenever update is presented.
module tb_bpu_update_ctrl;
  localparam int DEPTH = 4, IDX_W = 5, PC_W = 32, CNT_W = 3;

  logic             clk, rst_n;
  logic             enq_valid, enq_pred_taken, enq_ready;
  logic [PC_W-1:0]  enq_pc, enq_pred_target;
  logic             res_valid, res_taken;
  logic [PC_W-1:0]  res_target;
  logic [IDX_W-1:0] PC_lower_update;
  logic             update, update_direction, mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] count;
  logic             empty, res_err;

  bpu_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
    .enq_pred_target(enq_pred_target), .enq_ready(enq_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .PC_lower_update(PC_lower_update), .update(update),
    .update_direction(update_direction), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .count(count), .empty(empty), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic pt; logic [31:0] tgt; } ent_t;
  typedef struct { logic [4:0] idx; logic dir; logic mis; logic [31:0] rpc; } exp_t;

  ent_t model[$];
  exp_t expq[$];
  bit   m_err;
  int   n_cmp, n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (update) begin
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_update: got update=1 expected none at %0t", $time);
        end else begin
          e = expq.pop_front();
          chk("PC_lower_update", PC_lower_update, e.idx);
          chk("update_direction", update_direction, e.dir);
          chk("mispredict", mispredict, e.mis);
          if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
        end
      end else if (mispredict) begin
        n_cmp++; n_err++;
        $display("FAIL lone_mispredict: got mispredict=1 expected 0 (update=0) at %0t", $time);
      end
    end
  end

  // One clock of stimulus. Called at posedge+1: first checks status against the
  // model, then drives inputs and advances the model to the post-edge state.
  task automatic cyc(input bit ev, input logic [31:0] pc, input bit pt, input logic [31:0] tg,
                     input bit rv, input bit rt, input logic [31:0] rtg);
    ent_t h;
    bit   acc, mis;
    chk("count", count, model.size());
    chk("empty", empty, model.size() == 0);
    chk("enq_ready", enq_ready, model.size() < DEPTH);
    chk("res_err", res_err, m_err);
    enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    acc = ev && (model.size() < DEPTH);
    mis = 1'b0;
    if (rv) begin
      if (model.size() == 0) m_err = 1'b1;
      else begin
        h   = model.pop_front();
        mis = (h.pt != rt) || (h.pt && rt && h.tgt != rtg);
        expq.push_back(exp_t'{h.pc[4:0], rt, mis, rt ? rtg : h.pc + 32'd4});
        if (mis) model.delete();
      end
    end
    if (acc && !mis) model.push_back(ent_t'{pc, pt, tg});
    @(posedge clk); #1;
    enq_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq(input logic [31:0] pc, input bit pt, input logic [31:0] tg);
    cyc(1, pc, pt, tg, 0, 0, 0);
  endtask

  task automatic res(input bit rt, input logic [31:0] rtg);
    cyc(0, 0, 0, 0, 1, rt, rtg);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_update", update, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_PC_lower_update", PC_lower_update, 0);
    chk("rst_update_direction", update_direction, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_err = 1'b0;
    rst_n = 1'b0;
    enq_valid = 0; enq_pc = 0; enq_pred_taken = 0; enq_pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    #12;
    chk_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: correct taken prediction
    enq(32'h40, 1, 32'h80);
    res(1, 32'h80);
    idle(1);
    // 2: predicted not-taken, actually taken
    enq(32'h24, 0, 0);
    res(1, 32'h100);
    idle(1);
    // 3: direction mispredict flushes younger entries and a same-cycle enqueue
    enq(32'h10, 1, 32'h200);
    enq(32'h14, 1, 32'h200);
    enq(32'h18, 1, 32'h200);
    cyc(1, 32'h1C, 1, 32'h200, 1, 0, 0);
    idle(1);
    // 4: fill, drop when full, enq+res together, drain across the wrap
    enq(32'h50, 0, 0);
    enq(32'h54, 1, 32'h400);
    enq(32'h58, 0, 0);
    enq(32'h5C, 1, 32'h404);
    enq(32'h60, 1, 32'h408);             // dropped: full
    cyc(1, 32'h64, 0, 0, 1, 0, 0);       // full: only the pop happens
    cyc(1, 32'h68, 1, 32'h40C, 1, 1, 32'h400); // count 3 -> 3
    res(0, 0);
    res(1, 32'h404);
    res(1, 32'h40C);
    idle(1);
    // 6: same direction, wrong target
    enq(32'h70, 1, 32'h300);
    res(1, 32'h304);
    idle(1);
    // 5: resolve while empty is sticky; async reset with entries queued
    res(1, 32'h500);
    idle(2);
    enq(32'h80, 0, 0);
    enq(32'h84, 0, 0);
    idle(1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs();
    model.delete(); m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc, tg, rtg;
      pc  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      tg  = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000;
      rtg = ($urandom_range(0, 3) != 0) ? tg : 32'h3000;
      cyc($urandom_range(0, 99) < 60, pc, 1'($urandom_range(0, 1)), tg,
          $urandom_range(0, 99) < 40, 1'($urandom_range(0, 3) != 0), rtg);
    end
    idle(3);
    chk("pending_expectations", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
